// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared widths, refill FSM encoding and helpers for the data-cache miss handler.
// Also used by the cache arrays so both sides agree on the index/tag split.
package dcache_refill_ctrl_pkg;

   localparam int ADDR_W   = 32;
   localparam int INDEX_W  = 3;
   localparam int OFFSET_W = 3;
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
   localparam int WORD_W   = 32;
   localparam int LINE_W   = 2 * WORD_W;

   localparam logic [OFFSET_W-1:0] WORD0_OFS = 3'b000;
   localparam logic [OFFSET_W-1:0] WORD1_OFS = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD0  = 2'd1,
      RD1  = 2'd2,
      FILL = 2'd3
   } refill_state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/dcache_refill_ctrl_if.sv
// Pipeline, main-memory and cache-fill signals of the refill controller.
// The controller sits on the slave side; pipeline/memory/bench drive the master side.
interface dcache_refill_ctrl_if;
   import dcache_refill_ctrl_pkg::*;

   logic                MemRead;
   logic [ADDR_W-1:0]   endereco;
   logic                cache_hit;
   logic                mem_req;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_ready;
   logic [WORD_W-1:0]   mem_rdata;
   logic                fill_we;
   logic [INDEX_W-1:0]  fill_index;
   logic [TAG_W-1:0]    fill_tag;
   logic [LINE_W-1:0]   fill_data;
   logic                stall_refill;
   logic [31:0]         miss_count;

   modport slave (
      input  MemRead, endereco, cache_hit, mem_ready, mem_rdata,
      output mem_req, mem_addr, fill_we, fill_index, fill_tag, fill_data,
             stall_refill, miss_count
   );

   modport master (
      output MemRead, endereco, cache_hit, mem_ready, mem_rdata,
      input  mem_req, mem_addr, fill_we, fill_index, fill_tag, fill_data,
             stall_refill, miss_count
   );

endinterface

// File: rtl/dcache_refill_ctrl.sv
// Read-miss handler for the 8-line x 64-bit direct-mapped data cache: fetches the
// block as two words over req/ready and writes data, tag and valid in one strobe.
//
//   state | meaning
//   IDLE  | waiting for a load that misses
//   RD0   | requesting word 0 of the block (offset 0)
//   RD1   | requesting word 1 of the block (offset 4)
//   FILL  | fill_we high for one cycle, line written
module dcache_refill_ctrl
   import dcache_refill_ctrl_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   dcache_refill_ctrl_if.slave  bus
);

   refill_state_t state, state_next;

   logic miss_seen;
   logic latch_miss;
   logic take_w0;
   logic take_w1;

   logic [TAG_W-1:0]   tag_q;
   logic [INDEX_W-1:0] index_q;
   logic [WORD_W-1:0]  word0_q;

   logic               mem_req_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic               fill_we_q;
   logic [INDEX_W-1:0] fill_index_q;
   logic [TAG_W-1:0]   fill_tag_q;
   logic [LINE_W-1:0]  fill_data_q;
   logic [31:0]        miss_count_q;

   logic               unused_byte_ofs;

   assign miss_seen       = bus.MemRead & ~bus.cache_hit;
   assign unused_byte_ofs = ^bus.endereco[OFFSET_W-1:0];

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      latch_miss = 1'b0;
      take_w0    = 1'b0;
      take_w1    = 1'b0;
      case (state)
         IDLE: begin
            if (miss_seen) begin
               latch_miss = 1'b1;
               state_next = RD0;
            end
         end
         RD0: begin
            if (bus.mem_ready) begin
               take_w0    = 1'b1;
               state_next = RD1;
            end
         end
         RD1: begin
            if (bus.mem_ready) begin
               take_w1    = 1'b1;
               state_next = FILL;
            end
         end
         FILL:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request and fill outputs are loaded one cycle ahead of the state they belong to.
   always_ff @(posedge clock) begin
      if (reset) begin
         tag_q        <= '0;
         index_q      <= '0;
         word0_q      <= '0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         fill_we_q    <= 1'b0;
         fill_index_q <= '0;
         fill_tag_q   <= '0;
         fill_data_q  <= '0;
         miss_count_q <= '0;
      end else begin
         fill_we_q <= take_w1;
         if (latch_miss) begin
            tag_q        <= bus.endereco[ADDR_W-1 -: TAG_W];
            index_q      <= bus.endereco[OFFSET_W +: INDEX_W];
            mem_req_q    <= 1'b1;
            mem_addr_q   <= {bus.endereco[ADDR_W-1:OFFSET_W], WORD0_OFS};
            miss_count_q <= sat_inc(miss_count_q);
         end
         if (take_w0) begin
            word0_q    <= bus.mem_rdata;
            mem_addr_q <= {tag_q, index_q, WORD1_OFS};
         end
         if (take_w1) begin
            mem_req_q    <= 1'b0;
            fill_index_q <= index_q;
            fill_tag_q   <= tag_q;
            fill_data_q  <= {bus.mem_rdata, word0_q};
         end
      end
   end

   assign bus.mem_req      = mem_req_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.fill_we      = fill_we_q;
   assign bus.fill_index   = fill_index_q;
   assign bus.fill_tag     = fill_tag_q;
   assign bus.fill_data    = fill_data_q;
   assign bus.miss_count   = miss_count_q;
   assign bus.stall_refill = (state != IDLE) | miss_seen;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed bench for dcache_refill_ctrl: a block-level refill model checked every
// cycle, a wait-state memory responder, and literal expectations per scenario.
module tb_dcache_refill_ctrl;
   import dcache_refill_ctrl_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   dcache_refill_ctrl_if bus();

   dcache_refill_ctrl dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   int waits = 0;
   int wcnt = 0;
   bit manual = 1'b0;
   int hit_mode = 0;
   bit lv[8];
   logic [25:0] lt[8];

   int stall_cnt = 0;
   int fill_pulses = 0;
   int req_cycles = 0;
   logic [31:0] addr_log[$];

   bit          m_valid = 1'b0;
   bit          m_busy = 1'b0;
   int          m_words = 0;
   logic [31:0] m_blk = '0;
   logic [31:0] m_got[2];
   logic [31:0] m_cnt = '0;
   logic        e_req = 1'b0;
   logic [31:0] e_addr = '0;
   logic        e_fwe = 1'b0;
   logic [2:0]  e_fidx = '0;
   logic [25:0] e_ftag = '0;
   logic [63:0] e_fdata = '0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      if (reset) begin
         m_busy = 1'b0; m_words = 0; m_cnt = '0;
         e_req = 1'b0; e_addr = '0; e_fwe = 1'b0;
         e_fidx = '0; e_ftag = '0; e_fdata = '0;
         m_valid = 1'b1;
      end else begin
         e_fwe = 1'b0;
         if (!m_busy) begin
            if (bus.MemRead && !bus.cache_hit) begin
               m_busy = 1'b1;
               m_blk = bus.endereco & 32'hFFFF_FFF8;
               m_words = 0;
               if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
         end else if (m_words < 2) begin
            if (bus.mem_ready) begin
               m_got[m_words] = bus.mem_rdata;
               m_words++;
               if (m_words == 2) begin
                  e_fwe = 1'b1;
                  e_fidx = m_blk[5:3];
                  e_ftag = m_blk[31:6];
                  e_fdata = {m_got[1], m_got[0]};
               end
            end
         end else begin
            m_busy = 1'b0;
         end
         e_req = m_busy && (m_words < 2);
         if (e_req) e_addr = m_blk + 32'(4 * m_words);
      end
   endtask

   task automatic compare();
      if (m_valid) begin
         check("mem_req", 64'(bus.mem_req), 64'(e_req));
         check("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
         check("fill_we", 64'(bus.fill_we), 64'(e_fwe));
         check("fill_index", 64'(bus.fill_index), 64'(e_fidx));
         check("fill_tag", 64'(bus.fill_tag), 64'(e_ftag));
         check("fill_data", bus.fill_data, e_fdata);
         check("miss_count", 64'(bus.miss_count), 64'(m_cnt));
         check("stall_refill", 64'(bus.stall_refill),
               64'(m_busy || (bus.MemRead && !bus.cache_hit)));
      end
   endtask

   task automatic update_hit();
      logic [2:0] idx;
      idx = bus.endereco[5:3];
      case (hit_mode)
         1:       bus.cache_hit = 1'b1;
         2:       bus.cache_hit = 1'b0;
         default: bus.cache_hit = lv[idx] && (lt[idx] == bus.endereco[31:6]);
      endcase
   endtask

   task automatic respond();
      if (!manual) begin
         if (bus.mem_req) begin
            if (wcnt >= waits) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = memf(bus.mem_addr);
               wcnt = 0;
            end else begin
               bus.mem_ready = 1'b0;
               wcnt++;
            end
         end else begin
            bus.mem_ready = 1'b0;
            wcnt = 0;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clock);
      compare();
      if (bus.mem_req) req_cycles++;
      if (bus.mem_req && bus.mem_ready) addr_log.push_back(bus.mem_addr);
      if (bus.stall_refill) stall_cnt++;
      if (bus.fill_we) begin
         fill_pulses++;
         lv[bus.fill_index] = 1'b1;
         lt[bus.fill_index] = bus.fill_tag;
      end
      @(posedge clock);
      model_step();
      #1;
      respond();
      update_hit();
   endtask

   task automatic drive(input logic mr, input logic [31:0] a);
      bus.MemRead = mr;
      bus.endereco = a;
      update_hit();
   endtask

   task automatic clear_counts();
      stall_cnt = 0; fill_pulses = 0; req_cycles = 0;
      addr_log.delete();
   endtask

   task automatic wait_fill(input int target, input int budget);
      int k;
      k = 0;
      while (fill_pulses < target && k < budget) begin
         cycle();
         k++;
      end
      check("wait_fill_timeout", 64'(fill_pulses >= target), 64'd1);
   endtask

   task automatic check_log2(input string name, input logic [31:0] a0, input logic [31:0] a1);
      check({name, "_count"}, 64'(addr_log.size()), 64'd2);
      if (addr_log.size() >= 2) begin
         check({name, "_a0"}, 64'(addr_log[0]), 64'(a0));
         check({name, "_a1"}, 64'(addr_log[1]), 64'(a1));
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin lv[i] = 1'b0; lt[i] = '0; end
      bus.MemRead = 1'b0; bus.endereco = '0; bus.cache_hit = 1'b0;
      bus.mem_ready = 1'b0; bus.mem_rdata = '0;
      reset = 1'b1;
      repeat (3) cycle();
      reset = 1'b0;
      cycle();
      check("rst_mem_req", 64'(bus.mem_req), 64'd0);
      check("rst_fill_we", 64'(bus.fill_we), 64'd0);
      check("rst_miss_count", 64'(bus.miss_count), 64'd0);
      check("rst_stall", 64'(bus.stall_refill), 64'd0);

      // 1: zero-wait miss on 0x48
      clear_counts(); waits = 0;
      drive(1'b1, 32'h0000_0048);
      repeat (8) cycle();
      drive(1'b0, 32'h0000_0048);
      cycle();
      check_log2("t1_addr", 32'h48, 32'h4C);
      check("t1_fill_index", 64'(bus.fill_index), 64'd1);
      check("t1_fill_tag", 64'(bus.fill_tag), 64'h1);
      check("t1_fill_data", bus.fill_data, {memf(32'h4C), memf(32'h48)});
      check("t1_stall_cycles", 64'(stall_cnt), 64'd4);
      check("t1_miss_count", 64'(bus.miss_count), 64'd1);
      check("t1_fill_pulses", 64'(fill_pulses), 64'd1);

      // 2: three wait cycles per word
      clear_counts(); waits = 3;
      drive(1'b1, 32'h1234_5678);
      repeat (16) cycle();
      drive(1'b0, 32'h1234_5678);
      cycle();
      check_log2("t2_addr", 32'h1234_5678, 32'h1234_567C);
      check("t2_stall_cycles", 64'(stall_cnt), 64'd10);
      check("t2_fill_pulses", 64'(fill_pulses), 64'd1);
      check("t2_req_cycles", 64'(req_cycles), 64'd8);
      check("t2_fill_index", 64'(bus.fill_index), 64'd7);
      check("t2_fill_tag", 64'(bus.fill_tag), 64'h48D159);

      // 3: address and MemRead change during the refill
      clear_counts(); waits = 2;
      drive(1'b1, 32'h0000_0100);
      cycle();
      drive(1'b0, 32'h0000_0200);
      repeat (12) cycle();
      check_log2("t3_addr", 32'h100, 32'h104);
      check("t3_fill_index", 64'(bus.fill_index), 64'd0);
      check("t3_fill_tag", 64'(bus.fill_tag), 64'h4);
      check("t3_fill_pulses", 64'(fill_pulses), 64'd1);
      check("t3_miss_count", 64'(bus.miss_count), 64'd3);

      // 4: reset during RD1, then a stray mem_ready
      clear_counts(); manual = 1'b1; bus.mem_ready = 1'b0;
      drive(1'b1, 32'h0000_0300);
      cycle();
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_0001;
      drive(1'b0, 32'h0);
      cycle();
      bus.mem_ready = 1'b0;
      cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_0002;
      cycle();
      bus.mem_ready = 1'b0;
      repeat (4) cycle();
      manual = 1'b0;
      check("t4_mem_req", 64'(bus.mem_req), 64'd0);
      check("t4_fill_pulses", 64'(fill_pulses), 64'd0);
      check("t4_miss_count", 64'(bus.miss_count), 64'd0);
      check("t4_stall", 64'(bus.stall_refill), 64'd0);

      // 5: hit does not refill; no MemRead does not refill
      clear_counts(); waits = 0; hit_mode = 1;
      drive(1'b1, 32'h0000_0400);
      repeat (5) cycle();
      check("t5_hit_req_cycles", 64'(req_cycles), 64'd0);
      check("t5_hit_stall", 64'(stall_cnt), 64'd0);
      hit_mode = 2;
      drive(1'b0, 32'h0000_0400);
      repeat (5) cycle();
      check("t5_nord_req_cycles", 64'(req_cycles), 64'd0);
      check("t5_nord_stall", 64'(stall_cnt), 64'd0);
      check("t5_miss_count", 64'(bus.miss_count), 64'd0);
      hit_mode = 0;

      // 6: back-to-back misses to index 1
      clear_counts(); waits = 1;
      drive(1'b1, 32'h0000_0008);
      wait_fill(1, 30);
      cycle();
      drive(1'b1, 32'h0000_0048);
      wait_fill(2, 30);
      cycle();
      drive(1'b0, 32'h0);
      repeat (2) cycle();
      check("t6_miss_count", 64'(bus.miss_count), 64'd2);
      check("t6_fill_index", 64'(bus.fill_index), 64'd1);
      check("t6_fill_tag", 64'(bus.fill_tag), 64'h1);
      check("t6_line1_tag", 64'(lt[1]), 64'h1);
      check("t6_fill_pulses", 64'(fill_pulses), 64'd2);
      check("t6_req_words", 64'(addr_log.size()), 64'd4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
